// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache. Sits between the core's
// instruction SRAM-like port and the bridge's instruction port. Hits return
// one cycle after acceptance, misses refill a whole line word by word, and
// uncached fetches go straight through as a single-word read.
module inst_cache #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_uncached,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_uncached,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REF_REQ,
        S_REF_WAIT,
        S_UNC_REQ,
        S_UNC_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    // Line storage: valid bits are control state, tags and words are data.
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_ram  [SETS];
    logic [31:0]      data_ram [SETS][LINE_WORDS];

    // Request captured at acceptance; byte offset bits are never needed.
    logic [31:2]       req_addr;
    logic              req_unc;
    logic [WORD_W-1:0] cnt;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              hit;
    logic              accept;
    logic              refill_beat;
    logic              refill_done;
    logic              miss;

    // Byte-offset bits of the fetch address are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_word = req_addr[OFF_W-1:2];

    assign hit         = valid[req_idx] && (tag_ram[req_idx] == req_tag);
    assign accept      = (state == S_IDLE) && !flush && cpu_req;
    assign miss        = (state == S_LOOKUP) && !req_unc && !hit;
    assign refill_beat = (state == S_REF_WAIT) && mem_data_ok;
    assign refill_done = refill_beat && (cnt == LAST_WORD);

    // Constant fields of the read-only downstream port.
    assign mem_wr    = 1'b0;
    assign mem_size  = 2'b10;
    assign mem_wdata = 32'h0;

    // Next-state and output decode; every output idles at zero.
    always_comb begin
        state_next   = state;
        cpu_addr_ok  = 1'b0;
        cpu_data_ok  = 1'b0;
        cpu_rdata    = 32'h0;
        mem_req      = 1'b0;
        mem_addr     = 32'h0;
        mem_uncached = 1'b0;
        case (state)
            S_IDLE: begin
                // A pending flush blocks acceptance so it takes effect first.
                if (accept) begin
                    cpu_addr_ok = 1'b1;
                    state_next  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (req_unc) begin
                    state_next = S_UNC_REQ;
                end else if (hit) begin
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = data_ram[req_idx][req_word];
                    state_next  = S_IDLE;
                end else begin
                    state_next = S_REF_REQ;
                end
            end
            S_REF_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, cnt, 2'b00};
                if (mem_addr_ok) begin
                    state_next = S_REF_WAIT;
                end
            end
            S_REF_WAIT: begin
                // After the last word, re-enter LOOKUP so the fetch hits.
                if (mem_data_ok) begin
                    state_next = (cnt == LAST_WORD) ? S_LOOKUP : S_REF_REQ;
                end
            end
            S_UNC_REQ: begin
                mem_req      = 1'b1;
                mem_addr     = {req_addr[31:2], 2'b00};
                mem_uncached = 1'b1;
                if (mem_addr_ok) begin
                    state_next = S_UNC_WAIT;
                end
            end
            S_UNC_WAIT: begin
                // Downstream data is forwarded in the cycle it arrives.
                cpu_data_ok = mem_data_ok;
                cpu_rdata   = mem_data_ok ? mem_rdata : 32'h0;
                if (mem_data_ok) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register, valid bits and refill word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            valid <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && flush) begin
                valid <= '0;
            end else if (miss) begin
                // The victim is dropped before its words are overwritten, so
                // an interrupted refill can never expose a mixed line.
                valid[req_idx] <= 1'b0;
            end else if (refill_done) begin
                valid[req_idx] <= 1'b1;
            end
            if (miss) begin
                cnt <= '0;
            end else if (refill_beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Capture the fetch address and attribute when the request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr <= cpu_addr[31:2];
            req_unc  <= cpu_uncached;
        end
    end

    // Refill writes: one word per response, tag written with the last word.
    always_ff @(posedge clk) begin
        if (refill_beat) begin
            data_ram[req_idx][cnt] <= mem_rdata;
            if (cnt == LAST_WORD) begin
                tag_ram[req_idx] <= req_tag;
            end
        end
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the core's instruction SRAM-like port and the instruction port of the CPU-to-AXI bridge. Cached fetches hit in one cycle after acceptance. Misses refill a whole line as sequential single-word reads on the downstream SRAM-like port. Uncached fetches bypass the arrays as one single-word read.

## Interface
- `LINE_WORDS`, default 4: words per line; power of 2, ≥ 2.
- `SETS`, default 64: number of lines; power of 2.
- Derived widths:
  - `OFF_W = log2(LINE_WORDS) + 2`
  - `IDX_W = log2(SETS)`
  - `TAG_W = 32 - OFF_W - IDX_W`
- Address split: `addr[31 -: TAG_W]` is the tag, `addr[OFF_W +: IDX_W]` is the index, `addr[OFF_W-1:2]` is the word select.

Ports:
- `clk` in 1: the single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: invalidate all lines.
- `cpu_req` in 1: fetch request, held until `cpu_addr_ok`.
- `cpu_addr` in 32: fetch address; bits [1:0] are ignored.
- `cpu_uncached` in 1: bypass the cache for this fetch.
- `cpu_addr_ok` out 1: request accepted.
- `cpu_data_ok` out 1: `cpu_rdata` is valid this cycle.
- `cpu_rdata` out 32: fetched word.
- `mem_req` out 1: downstream request.
- `mem_wr` out 1: tied to 0.
- `mem_size` out 2: tied to 2'b10 (word).
- `mem_addr` out 32: word-aligned downstream address.
- `mem_wdata` out 32: tied to 0.
- `mem_uncached` out 1: uncached attribute for the downstream request.
- `mem_rdata` in 32: downstream read data.
- `mem_addr_ok` in 1: downstream accepted the request.
- `mem_data_ok` in 1: downstream data valid.

## Operation
- Storage:
  - `valid[SETS]`, held in flops.
  - `tag[SETS][TAG_W]`.
  - `data[SETS][LINE_WORDS][32]`, read combinationally from the latched address.
- Latched on accept: `req_addr` and `req_unc`. A word counter `cnt` of width log2(LINE_WORDS).
- At most one CPU request is outstanding. `cpu_addr_ok` is asserted only in IDLE.

State machine:
- **IDLE**
  - If `flush`: clear all `valid`; `cpu_addr_ok = 0`. `flush` has priority over `cpu_req`.
  - Else `cpu_addr_ok = cpu_req`. On accept, latch address and uncached flag, then go to LOOKUP.
- **LOOKUP**
  - If `req_unc`, go to UNC_REQ.
  - Else, if `valid[idx] && tag[idx] == req_tag` (hit): `cpu_data_ok = 1`, `cpu_rdata = data[idx][word]`, go to IDLE.
  - Else (miss): `cnt = 0`, go to REF_REQ.
- **REF_REQ**
  - `mem_req = 1`, `mem_addr = {req_tag, idx, cnt, 2'b00}`, `mem_uncached = 0`.
  - On `mem_addr_ok`, go to REF_WAIT.
- **REF_WAIT**
  - On `mem_data_ok`: `data[idx][cnt] <= mem_rdata`.
  - If `cnt == LINE_WORDS-1`: `valid[idx] <= 1`, `tag[idx] <= req_tag`, go to LOOKUP. The re-lookup then hits.
  - Otherwise `cnt++` and go to REF_REQ.
- **UNC_REQ**
  - `mem_req = 1`, `mem_addr = {req_addr[31:2], 2'b00}`, `mem_uncached = 1`.
  - On `mem_addr_ok`, go to UNC_WAIT.
- **UNC_WAIT**
  - `cpu_data_ok = mem_data_ok`, `cpu_rdata = mem_rdata`, passed through in the same cycle.
  - On `mem_data_ok`, go to IDLE. The arrays are not modified.

Rules and boundary conditions:
- `mem_data_ok` is only consumed in the WAIT states. The downstream returns data no earlier than the cycle after `mem_addr_ok`; `mem_data_ok` in any other state is ignored.
- `valid[idx]` stays 0 during refill until the last word is written; a partial line is never visible.
- The victim line is overwritten unconditionally. There is no write-back, since the cache is read-only.
- `flush` outside IDLE is ignored; the requester holds it until IDLE. A flush never corrupts an in-progress refill.
- Refill order is word 0 to word LINE_WORDS-1 regardless of the requested word.
- `cpu_rdata` is 0 whenever `cpu_data_ok = 0`.

## Timing
- Reset values: state IDLE, all `valid = 0`, `cnt = 0`. All outputs are 0 except `mem_size = 2'b10`.
- Reset mid-refill or mid-uncached access: return to IDLE immediately and drop the line. The downstream bridge shares `rst`, so no stale response arrives.
- Hit: accepted at cycle T, `cpu_data_ok` at T+1.
- Miss: for each word, one REF_REQ cycle, plus downstream acceptance wait, plus response wait. `cpu_data_ok` is asserted in the LOOKUP cycle after the last word.
- Minimum miss latency with zero-wait downstream (`addr_ok` on first request cycle, `data_ok` next cycle): 2·LINE_WORDS + 2 cycles from accept. That is 10 cycles at the default LINE_WORDS = 4.
- Uncached: `cpu_data_ok` arrives in the same cycle as `mem_data_ok`.
- `mem_req` is held high continuously in REQ states until `mem_addr_ok`, with address stable. It is never asserted in other states.
- A new CPU request is accepted at earliest the cycle after `cpu_data_ok`.

## Test plan
- **Cold miss then hit:** after reset, fetch 0xBFC00004 cached. Expect:
  - Four `mem_req` at 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C with `mem_uncached = 0`.
  - `cpu_rdata` equals the word returned for 0xBFC00004.
  - Re-fetching 0xBFC00008 gives `cpu_data_ok` at T+1 with no `mem_req`.
- **Conflict eviction:** fill 0x00000000, then fetch 0x00000400 (same index, default params). Expect a refill at 0x400–0x40C; fetching 0x0 again misses and refills.
- **Uncached bypass:** fetch 0xBFC00010 with `cpu_uncached = 1`. Expect:
  - Exactly one `mem_req` at 0xBFC00010 with `mem_uncached = 1`.
  - Data passed through in the same cycle as `mem_data_ok`.
  - A following cached fetch of 0xBFC00010 still misses.
- **Flush priority:** in IDLE with `flush = 1` and `cpu_req = 1` at a previously cached address. Expect `cpu_addr_ok = 0` that cycle; the next accepted fetch misses and refills.
- **Backpressure:** downstream delays `mem_addr_ok` 3 cycles and `mem_data_ok` 5 cycles per word. Expect `mem_addr` stable while waiting, correct line contents, and a single `cpu_data_ok`.
- **Reset mid-refill:** assert `rst` after the 2nd refill word. Expect outputs back at reset values next cycle; the same address fetched afterwards misses and performs a full 4-word refill.
